// File: rtl/script_sequencer.sv
// script_sequencer: fetch/decode/dispatch/retire loop for the kitchen script engine.
// Starts one execution unit per instruction and waits for its done before moving pc.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | stopped, waiting for run_en
// FETCH     | pc stable, script memory read in flight
// DECODE    | latch script word, choose unit / NOP / HALT
// DISPATCH  | single-cycle start pulse to the selected unit, arm watchdog
// WAIT_DONE | waiting for the selected unit's done, watchdog counting
// ADVANCE   | update pc, count the retired instruction
// STEP_HOLD | single-step pause until step_pulse
// HALT      | halt opcode or watchdog expiry; only res leaves
module script_sequencer #(
   parameter int unsigned TIMEOUT_MS = 5000,
   parameter int unsigned PC_STEP    = 2
) (
   input  logic        clk,
   input  logic        res,
   input  logic        run_en,
   input  logic        step_mode,
   input  logic        step_pulse,
   input  logic        ms_tick,
   input  logic [15:0] script,
   input  logic [3:0]  unit_done,
   input  logic        jump_taken,
   input  logic [7:0]  jump_target,
   output logic [7:0]  pc,
   output logic [15:0] instr,
   output logic [3:0]  unit_start,
   output logic        busy,
   output logic        halted,
   output logic        error,
   output logic [7:0]  retired_cnt
);

   localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS + 1) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_MS);
   localparam logic [TW-1:0] TIMER_LAST = TW'(1);
   localparam logic [7:0]    PC_INC     = 8'(PC_STEP);
   localparam bit            WDOG_EN    = (TIMEOUT_MS != 0);
   localparam logic [1:0]    UNIT_JUMP  = 2'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_DISPATCH,
      S_WAIT_DONE,
      S_ADVANCE,
      S_STEP_HOLD,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      op;
   logic [1:0]      unit_idx_q;
   logic [TW-1:0]   timer_q;
   logic            jump_q;
   logic [7:0]      jump_pc_q;
   logic            done_hit;
   logic            wdog_expire;

   assign op     = script[2:0];
   assign busy   = !((state_q == S_IDLE) || (state_q == S_STEP_HOLD) || (state_q == S_HALT));
   assign halted = (state_q == S_HALT);

   // next-state decode and the dispatch start pulse
   always_comb begin
      state_d     = state_q;
      done_hit    = 1'b0;
      wdog_expire = 1'b0;
      unit_start  = 4'b0000;
      case (state_q)
         S_IDLE: begin
            if (run_en) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               3'b001, 3'b010, 3'b011, 3'b100: state_d = S_DISPATCH;
               3'b111:                         state_d = S_HALT;
               default:                        state_d = S_ADVANCE;
            endcase
         end
         S_DISPATCH: begin
            unit_start[unit_idx_q] = 1'b1;
            state_d                = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // done beats a final tick landing in the same cycle
            if (unit_done[unit_idx_q]) begin
               done_hit = 1'b1;
               state_d  = S_ADVANCE;
            end else if (WDOG_EN && ms_tick && (timer_q == TIMER_LAST)) begin
               wdog_expire = 1'b1;
               state_d     = S_HALT;
            end
         end
         S_ADVANCE: begin
            if (!run_en)        state_d = S_IDLE;
            else if (step_mode) state_d = S_STEP_HOLD;
            else                state_d = S_FETCH;
         end
         S_STEP_HOLD: begin
            if (!run_en)                       state_d = S_IDLE;
            else if (step_pulse || !step_mode) state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (res) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // datapath: instruction latch, watchdog down-counter, jump capture, pc and retire count
   always_ff @(posedge clk) begin
      if (res) begin
         pc          <= 8'h00;
         instr       <= 16'h0000;
         unit_idx_q  <= 2'd0;
         timer_q     <= '0;
         jump_q      <= 1'b0;
         jump_pc_q   <= 8'h00;
         error       <= 1'b0;
         retired_cnt <= 8'h00;
      end else begin
         case (state_q)
            S_DECODE: begin
               instr      <= script;
               unit_idx_q <= 2'(op - 3'd1);
               jump_q     <= 1'b0;
            end
            S_DISPATCH: begin
               timer_q <= TIMER_LOAD;
            end
            S_WAIT_DONE: begin
               if (done_hit) begin
                  if (unit_idx_q == UNIT_JUMP) begin
                     jump_q    <= jump_taken;
                     jump_pc_q <= jump_target & 8'hFE;
                  end
               end else if (wdog_expire) begin
                  error <= 1'b1;
               end else if (ms_tick && (timer_q != '0)) begin
                  timer_q <= timer_q - TIMER_LAST;
               end
            end
            S_ADVANCE: begin
               pc <= jump_q ? jump_pc_q : pc + PC_INC;
               if (retired_cnt != 8'hFF) retired_cnt <= retired_cnt + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_script_sequencer.sv
// Testbench for script_sequencer: directed vector table, randomized instruction
// stream against an instruction-level model, and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_script_sequencer;

   localparam int TMO = 3;

   logic        clk = 1'b0;
   logic        res;
   logic        run_en;
   logic        step_mode;
   logic        step_pulse;
   logic        ms_tick;
   logic [15:0] script;
   logic [3:0]  unit_done;
   logic        jump_taken;
   logic [7:0]  jump_target;
   logic [7:0]  pc;
   logic [15:0] instr;
   logic [3:0]  unit_start;
   logic        busy;
   logic        halted;
   logic        error;
   logic [7:0]  retired_cnt;

   logic [15:0] mem [128];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] word;
      int          dly;
      logic        tk;
      logic [7:0]  tg;
      bit          spur;
      logic [3:0]  exp_start;
      logic [7:0]  exp_pc;
      int          exp_lat;
   } vec_t;

   vec_t vecs [11];

   script_sequencer #(.TIMEOUT_MS(TMO), .PC_STEP(2)) dut (
      .clk         (clk),
      .res         (res),
      .run_en      (run_en),
      .step_mode   (step_mode),
      .step_pulse  (step_pulse),
      .ms_tick     (ms_tick),
      .script      (script),
      .unit_done   (unit_done),
      .jump_taken  (jump_taken),
      .jump_target (jump_target),
      .pc          (pc),
      .instr       (instr),
      .unit_start  (unit_start),
      .busy        (busy),
      .halted      (halted),
      .error       (error),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   assign script = mem[pc[7:1]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      res = 1'b1; run_en = 1'b0; step_mode = 1'b0; step_pulse = 1'b0; ms_tick = 1'b0;
      unit_done = 4'b0000; jump_taken = 1'b0; jump_target = 8'h00;
      repeat (2) @(negedge clk);
      res = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_start();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (unit_start != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
      chk("start_reached", 32'(ok), 32'd1);
   endtask

   // Called at a negedge with the DUT in FETCH; plays the execution unit and
   // returns when the instruction retires (or the cycle budget expires).
   task automatic run_one(input logic [15:0] word, input int dly, input logic tk,
                          input logic [7:0] tg, input bit spur,
                          output int lat, output logic [3:0] start_seen, output int n_starts);
      logic [7:0] rc0;
      logic [3:0] bitm;
      bit         pend;
      int         cd;
      rc0 = retired_cnt; bitm = 4'b0000; pend = 1'b0; cd = 0;
      lat = -1; start_seen = 4'b0000; n_starts = 0;
      mem[pc[7:1]] = word;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         unit_done   = 4'b0000;
         jump_taken  = 1'($urandom);
         jump_target = 8'($urandom);
         if (retired_cnt != rc0) begin
            lat = k;
            break;
         end
         if (unit_start != 4'b0000) begin
            start_seen |= unit_start;
            n_starts++;
            bitm = unit_start; pend = 1'b1; cd = dly;
            unit_done = 4'($urandom) & ~bitm;
            if (spur) unit_done |= bitm;
         end else if (pend) begin
            if (cd == 0) begin
               unit_done = bitm; jump_taken = tk; jump_target = tg; pend = 1'b0;
            end else begin
               cd--;
               unit_done = 4'($urandom) & ~bitm;
            end
         end else begin
            unit_done = 4'($urandom);
         end
      end
      unit_done = 4'b0000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         lat;
      logic [3:0] st;
      int         ns;
      int         op;
      int         dly;
      logic       tk;
      logic [7:0] tg;
      bit         spur;
      logic [15:0] w;
      logic [7:0] model_pc;
      int         model_ret;
      logic [3:0] exp_start;
      int         exp_lat;

      vecs[0]  = '{16'h0001, 1, 1'b0, 8'h00, 1'b0, 4'b0001, 8'h02, 6};
      vecs[1]  = '{16'h1230, 0, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h04, 3};
      vecs[2]  = '{16'h00A2, 0, 1'b1, 8'h11, 1'b0, 4'b0010, 8'h10, 5};
      vecs[3]  = '{16'h0003, 2, 1'b0, 8'h00, 1'b0, 4'b0100, 8'h12, 7};
      vecs[4]  = '{16'h0005, 0, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h14, 3};
      vecs[5]  = '{16'hFFF2, 0, 1'b0, 8'h40, 1'b0, 4'b0010, 8'h16, 5};
      vecs[6]  = '{16'h0004, 3, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h18, 8};
      vecs[7]  = '{16'h8006, 0, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h1A, 3};
      vecs[8]  = '{16'h0002, 0, 1'b1, 8'hFF, 1'b0, 4'b0010, 8'hFE, 5};
      vecs[9]  = '{16'h0000, 0, 1'b0, 8'h00, 1'b0, 4'b0000, 8'h00, 3};
      vecs[10] = '{16'h0009, 2, 1'b0, 8'h00, 1'b1, 4'b0001, 8'h02, 7};

      // reset state
      do_reset();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_instr", 32'(instr), 32'h0);
      chk("rst_unit_start", 32'(unit_start), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      chk("rst_retired", 32'(retired_cnt), 32'h0);
      repeat (3) @(negedge clk);
      chk("idle_hold_busy", 32'(busy), 32'h0);

      // directed vector table
      run_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         run_one(vecs[i].word, vecs[i].dly, vecs[i].tk, vecs[i].tg, vecs[i].spur, lat, st, ns);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_start", i), 32'(st), 32'(vecs[i].exp_start));
         chk($sformatf("vec%0d_nstarts", i), 32'(ns), (vecs[i].exp_start != 4'b0) ? 32'd1 : 32'd0);
         chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
         chk($sformatf("vec%0d_retired", i), 32'(retired_cnt), 32'(i + 1));
         chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].word));
      end

      // HALT opcode: pc and retire count frozen
      mem[1] = 16'h0007;
      repeat (4) @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_pc", 32'(pc), 32'h02);
      chk("halt_retired", 32'(retired_cnt), 32'd11);
      chk("halt_instr", 32'(instr), 32'h0007);
      chk("halt_error", 32'(error), 32'd0);

      // randomized instruction stream against the instruction-level model
      do_reset();
      model_pc = 8'h00; model_ret = 0;
      run_en = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 120; n++) begin
         op   = int'($urandom_range(0, 6));
         w    = 16'($urandom);
         w[2:0] = 3'(op);
         dly  = int'($urandom_range(0, 5));
         tk   = 1'($urandom);
         tg   = 8'($urandom);
         spur = ($urandom_range(0, 3) == 0);
         exp_start = (op >= 1 && op <= 4) ? 4'(1 << (op - 1)) : 4'b0000;
         exp_lat   = (exp_start != 4'b0) ? 5 + dly : 3;
         run_one(w, dly, tk, tg, spur, lat, st, ns);
         model_pc  = (op == 2 && tk) ? {tg[7:1], 1'b0} : model_pc + 8'd2;
         model_ret = model_ret + 1;
         chk("rnd_latency", 32'(lat), 32'(exp_lat));
         chk("rnd_start", 32'(st), 32'(exp_start));
         chk("rnd_nstarts", 32'(ns), (exp_start != 4'b0) ? 32'd1 : 32'd0);
         chk("rnd_pc", 32'(pc), 32'(model_pc));
         chk("rnd_retired", 32'(retired_cnt), 32'(model_ret));
      end

      // single-step over NOPs; pulses outside STEP_HOLD are not queued
      do_reset();
      step_mode = 1'b1; run_en = 1'b1;
      repeat (6) @(negedge clk);
      chk("step0_pc", 32'(pc), 32'h02);
      chk("step0_busy", 32'(busy), 32'd0);
      chk("step0_retired", 32'(retired_cnt), 32'd1);
      step_pulse = 1'b1;
      @(negedge clk);           // FETCH: pulse still high, must be ignored
      @(negedge clk);           // DECODE
      step_pulse = 1'b0;
      @(negedge clk);           // ADVANCE: stray pulse, must be ignored
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      repeat (6) @(negedge clk);
      chk("step1_pc", 32'(pc), 32'h04);
      chk("step1_retired", 32'(retired_cnt), 32'd2);
      chk("step1_busy", 32'(busy), 32'd0);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      repeat (6) @(negedge clk);
      chk("step2_pc", 32'(pc), 32'h06);
      chk("step2_retired", 32'(retired_cnt), 32'd3);
      step_mode = 1'b0;
      @(negedge clk);
      chk("step_release_busy", 32'(busy), 32'd1);
      run_en = 1'b0;

      // watchdog: 3 ticks without done -> error + HALT; only res leaves
      do_reset();
      mem[0] = 16'h0003;
      run_en = 1'b1;
      wait_start();
      chk("wdog_start", 32'(unit_start), 32'b0100);
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk); ms_tick = 1'b1;
         @(negedge clk); ms_tick = 1'b0;
         chk($sformatf("wdog_error_t%0d", t), 32'(error), (t < 3) ? 32'd0 : 32'd1);
         chk($sformatf("wdog_halted_t%0d", t), 32'(halted), (t < 3) ? 32'd0 : 32'd1);
      end
      step_pulse = 1'b1; unit_done = 4'b0100;
      @(negedge clk);
      step_pulse = 1'b0; unit_done = 4'b0000; run_en = 1'b0;
      repeat (3) @(negedge clk);
      run_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("halt_sticky_halted", 32'(halted), 32'd1);
      chk("halt_sticky_error", 32'(error), 32'd1);
      chk("halt_sticky_pc", 32'(pc), 32'h00);
      chk("halt_sticky_retired", 32'(retired_cnt), 32'd0);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0; run_en = 1'b0;
      @(negedge clk);
      chk("res_clear_error", 32'(error), 32'd0);
      chk("res_clear_halted", 32'(halted), 32'd0);

      // done and final tick in the same cycle: done wins
      do_reset();
      mem[0] = 16'h0003;
      run_en = 1'b1;
      wait_start();
      for (int t = 1; t <= 2; t++) begin
         @(negedge clk); ms_tick = 1'b1;
         @(negedge clk); ms_tick = 1'b0;
      end
      @(negedge clk); ms_tick = 1'b1; unit_done = 4'b0100;
      @(negedge clk); ms_tick = 1'b0; unit_done = 4'b0000;
      chk("race_error", 32'(error), 32'd0);
      chk("race_halted", 32'(halted), 32'd0);
      @(negedge clk);
      chk("race_pc", 32'(pc), 32'h02);
      chk("race_retired", 32'(retired_cnt), 32'd1);
      run_en = 1'b0;

      // run_en dropped while waiting; wrong done bits ignored
      do_reset();
      mem[0] = 16'h0001;
      run_en = 1'b1;
      wait_start();
      @(negedge clk); run_en = 1'b0; unit_done = 4'b1110;
      @(negedge clk); unit_done = 4'b0000;
      chk("drop_wait_busy", 32'(busy), 32'd1);
      chk("drop_wait_pc", 32'(pc), 32'h00);
      chk("drop_wait_retired", 32'(retired_cnt), 32'd0);
      @(negedge clk); unit_done = 4'b0001;
      @(negedge clk); unit_done = 4'b0000;
      chk("drop_advance_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("drop_idle_busy", 32'(busy), 32'd0);
      chk("drop_idle_pc", 32'(pc), 32'h02);
      chk("drop_idle_retired", 32'(retired_cnt), 32'd1);
      repeat (3) @(negedge clk);
      chk("drop_hold_pc", 32'(pc), 32'h02);

      // retire counter saturation over a NOP-only script (pc wraps repeatedly)
      do_reset();
      run_en = 1'b1;
      repeat (800) @(negedge clk);
      chk("sat_retired", 32'(retired_cnt), 32'd255);
      chk("sat_busy", 32'(busy), 32'd1);
      run_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/script_sequencer.md
Name: script_sequencer

Overview:
- Instruction sequencer for the kitchen script engine.
- Owns the script program counter and fetches 16-bit script words from script memory.
- Decodes op_code, starts exactly one execution unit (action, jump, wait, game) per instruction and waits for that unit's done handshake before advancing.
- Replaces free-running pc update with a strict fetch/dispatch/retire loop, plus single-step mode and a per-instruction watchdog.

Parameters:
- TIMEOUT_MS, 5000, ms_tick count allowed per dispatched instruction before error; 0 disables the watchdog.
- PC_STEP, 2, pc increment per instruction (byte-addressed 16-bit words).

Ports:
- clk  input  1  system clock
- res  input  1  synchronous active-high reset
- run_en  input  1  level; sequencer runs while high
- step_mode  input  1  1 = stop after each retired instruction until step_pulse
- step_pulse  input  1  single-cycle, already-debounced step request
- ms_tick  input  1  single-cycle pulse every millisecond
- script  input  16  script memory read data; valid one cycle after pc changes
- unit_done  input  4  per-unit completion pulse: [0] action, [1] jump, [2] wait, [3] game
- jump_taken  input  1  jump unit result, sampled with unit_done[1]
- jump_target  input  8  jump destination, sampled with unit_done[1]
- pc  output  8  script memory address
- instr  output  16  latched current instruction (i_num/i_sign/func fields for units)
- unit_start  output  4  one-hot, single-cycle start; same bit order as unit_done
- busy  output  1  high in any state except IDLE, STEP_HOLD and HALT
- halted  output  1  high in HALT
- error  output  1  sticky watchdog flag
- retired_cnt  output  8  instructions retired, saturates at 255

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE, pc=0, instr=0, unit_start=0, error=0, retired_cnt=0, timer=0. Exit from HALT only via res.
- IDLE: if run_en, go to FETCH; else hold.
- FETCH (1 cycle): pc is stable. Next cycle goes to DECODE.
- DECODE: latch script into instr. Decode op = script[2:0]:
  - 001 action, 010 jump, 011 wait, 100 game: go to DISPATCH.
  - 000, 101, 110 (NOP): go to ADVANCE with no start pulse.
  - 111 (HALT): go to HALT; pc unchanged; no retire.
- DISPATCH (1 cycle): unit_start[idx]=1, all other bits 0. Clear timer. Go to WAIT_DONE.
- WAIT_DONE:
  - Only unit_done[idx] is honoured. Other bits, and any done arriving during DISPATCH, are ignored.
  - On done: go to ADVANCE. For jump, register jump_taken and jump_target the same cycle.
  - Each ms_tick increments the timer. If the timer reaches TIMEOUT_MS (TIMEOUT_MS != 0) without done: error=1, go to HALT.
  - If done and the final tick land in the same cycle, done wins.
- ADVANCE (1 cycle):
  - Jump taken: pc = {jump_target[7:1],1'b0}.
  - Otherwise: pc = pc + PC_STEP, modulo 256 (0xFE -> 0x00).
  - retired_cnt += 1, saturating at 255.
  - Next state: if !run_en, IDLE; else if step_mode, STEP_HOLD; else FETCH.
- STEP_HOLD:
  - step_pulse while run_en: go to FETCH.
  - run_en low: go to IDLE.
  - step_mode cleared: go to FETCH.
- run_en deasserted mid-instruction: the current instruction completes through ADVANCE, then the sequencer stops in IDLE with pc at the next instruction.
- step_pulse is ignored outside STEP_HOLD and is not queued.
- Latency, free-running: NOP takes 3 cycles (FETCH, DECODE, ADVANCE). A dispatched instruction takes 4 cycles + done delay (done on the first WAIT_DONE cycle gives 5 cycles per instruction).
- instr holds its value until the next DECODE. unit_start is never asserted in any state except DISPATCH.

Test Plan:
- Reset, run_en=1, memory 0x0000 = 0x0001 (action), done returned 2 cycles after start -> unit_start=4'b0001 for exactly 1 cycle; pc goes 0x00 -> 0x02; retired_cnt=1.
- Jump word at pc 0x04, jump_taken=1, jump_target=0x11 with done -> pc=0x10 next; with jump_taken=0 -> pc=0x06.
- step_mode=1, three NOPs -> pc advances exactly one word per step_pulse; a step_pulse issued during FETCH is ignored.
- Wait instruction with TIMEOUT_MS=3 and no done -> error=1 and halted=1 after the 3rd ms_tick; a later step_pulse or run_en toggle does not leave HALT; res clears both flags.
- pc=0xFE holding a NOP -> pc wraps to 0x00. Word 0x0007 -> HALT with pc unchanged and retired_cnt unchanged.
- Drop run_en during WAIT_DONE, then return done -> ADVANCE, then IDLE, busy=0, pc=next word. Also: wrong unit_done bit while waiting -> ignored, state stays WAIT_DONE.
